// File: rtl/dram_if.sv
// Expansion-bus DRAM port: 68000 strobes and address in, multiplexed DRAM strobes and DTACK out.
interface dram_if #(
    parameter int unsigned ADDR_BITS = 11
);
    logic                   EXP;
    logic                   AS;
    logic                   UDS;
    logic                   LDS;
    logic                   RW;
    logic [2*ADDR_BITS-1:0] ADDR;
    logic [ADDR_BITS-1:0]   DRAM_ADDR;
    logic                   RAS_N;
    logic                   CAS_HI_N;
    logic                   CAS_LO_N;
    logic                   WE_N;
    logic                   DTACK_EXP;

    // CPU / system-controller side
    modport master (
        output EXP, AS, UDS, LDS, RW, ADDR,
        input  DRAM_ADDR, RAS_N, CAS_HI_N, CAS_LO_N, WE_N, DTACK_EXP
    );

    // DRAM controller side
    modport slave (
        input  EXP, AS, UDS, LDS, RW, ADDR,
        output DRAM_ADDR, RAS_N, CAS_HI_N, CAS_LO_N, WE_N, DTACK_EXP
    );
endinterface

// File: rtl/dram_controller.sv
// Asynchronous DRAM controller for the expansion bus: row/column multiplexing,
// RAS/CAS/WE sequencing, CAS-before-RAS refresh and DTACK_EXP generation.
// Optional build macro DRAM_SLOW_EN inserts a WAIT state so DTACK_EXP trails CAS
// by one cycle (80 ns parts).
module dram_controller #(
    parameter int unsigned REFRESH_CYCLES   = 300,
    parameter int unsigned PRECHARGE_CYCLES = 2,
    parameter int unsigned ADDR_BITS        = 11
) (
    input  logic  CLK,
    input  logic  RST,
    dram_if.slave bus
);

    localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned PRE_W = (PRECHARGE_CYCLES > 1) ? $clog2(PRECHARGE_CYCLES) : 1;
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PRECHARGE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RAS,
        S_COL,
        S_CAS,
`ifdef DRAM_SLOW_EN
        S_WAIT,
`endif
        S_HOLD,
        S_PRE,
        S_REF_CAS,
        S_REF_RAS,
        S_REF_HOLD
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [REF_W-1:0]     ref_cnt;
    logic                 ref_pending;
    logic [PRE_W-1:0]     pre_cnt;
    logic                 ref_expire_c;
    logic                 ref_take_c;
    logic [ADDR_BITS-1:0] row_c;
    logic [ADDR_BITS-1:0] col_c;

    logic [ADDR_BITS-1:0] dram_addr_q, dram_addr_d;
    logic                 ras_n_q,     ras_n_d;
    logic                 cas_hi_n_q,  cas_hi_n_d;
    logic                 cas_lo_n_q,  cas_lo_n_d;
    logic                 we_n_q,      we_n_d;
    logic                 dtack_q,     dtack_d;

    assign row_c = bus.ADDR[2*ADDR_BITS-1:ADDR_BITS];
    assign col_c = bus.ADDR[ADDR_BITS-1:0];

    // An expiry seen in IDLE is served at once, so refresh beats a same-edge access request
    assign ref_expire_c = (ref_cnt == '0);
    assign ref_take_c   = (state == S_IDLE) && (ref_pending || ref_expire_c);

    // Refresh interval counter and single-entry request flag (extra expiries are dropped)
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ref_cnt     <= REF_RELOAD;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt <= ref_expire_c ? REF_RELOAD : ref_cnt - REF_W'(1);
            if (ref_take_c) begin
                ref_pending <= 1'b0;
            end else if (ref_expire_c) begin
                ref_pending <= 1'b1;
            end
        end
    end

    // State register, precharge counter and registered DRAM-side outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            dram_addr_q <= '0;
            ras_n_q     <= 1'b1;
            cas_hi_n_q  <= 1'b1;
            cas_lo_n_q  <= 1'b1;
            we_n_q      <= 1'b1;
            dtack_q     <= 1'b1;
        end else begin
            state       <= state_nxt;
            pre_cnt     <= (state == S_PRE) ? pre_cnt + PRE_W'(1) : '0;
            dram_addr_q <= dram_addr_d;
            ras_n_q     <= ras_n_d;
            cas_hi_n_q  <= cas_hi_n_d;
            cas_lo_n_q  <= cas_lo_n_d;
            we_n_q      <= we_n_d;
            dtack_q     <= dtack_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ref_take_c) begin
                    state_nxt = S_REF_CAS;
                end else if (!bus.AS && !bus.EXP) begin
                    state_nxt = S_RAS;
                end
            end
            S_RAS:      state_nxt = S_COL;
            S_COL: begin
                // Write strobes may trail AS; reads go straight on
                if (bus.RW || !bus.UDS || !bus.LDS) begin
                    state_nxt = S_CAS;
                end
            end
`ifdef DRAM_SLOW_EN
            S_CAS:      state_nxt = S_WAIT;
            S_WAIT:     state_nxt = S_HOLD;
`else
            S_CAS:      state_nxt = S_HOLD;
`endif
            S_HOLD: begin
                if (bus.AS) begin
                    state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                if (pre_cnt == PRE_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            S_REF_CAS:  state_nxt = S_REF_RAS;
            S_REF_RAS:  state_nxt = S_REF_HOLD;
            S_REF_HOLD: state_nxt = S_PRE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next value of each registered output, holding by default
    always_comb begin
        dram_addr_d = dram_addr_q;
        ras_n_d     = ras_n_q;
        cas_hi_n_d  = cas_hi_n_q;
        cas_lo_n_d  = cas_lo_n_q;
        we_n_d      = we_n_q;
        dtack_d     = dtack_q;
        case (state)
            S_IDLE:  dram_addr_d = row_c;
            S_RAS:   ras_n_d = 1'b0;
            S_COL: begin
                dram_addr_d = col_c;
                we_n_d      = bus.RW;
            end
            S_CAS: begin
                cas_hi_n_d = bus.UDS;
                cas_lo_n_d = bus.LDS;
`ifdef DRAM_SLOW_EN
                dtack_d    = 1'b1;
`else
                dtack_d    = 1'b0;
`endif
            end
`ifdef DRAM_SLOW_EN
            S_WAIT:  dtack_d = 1'b0;
`endif
            S_HOLD: begin
                if (bus.AS) begin
                    ras_n_d    = 1'b1;
                    cas_hi_n_d = 1'b1;
                    cas_lo_n_d = 1'b1;
                    we_n_d     = 1'b1;
                    dtack_d    = 1'b1;
                end
            end
            S_REF_CAS: begin
                cas_hi_n_d = 1'b0;
                cas_lo_n_d = 1'b0;
                we_n_d     = 1'b1;
            end
            S_REF_RAS: ras_n_d = 1'b0;
            S_REF_HOLD: begin
                ras_n_d    = 1'b1;
                cas_hi_n_d = 1'b1;
                cas_lo_n_d = 1'b1;
                we_n_d     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.DRAM_ADDR = dram_addr_q;
    assign bus.RAS_N     = ras_n_q;
    assign bus.CAS_HI_N  = cas_hi_n_q;
    assign bus.CAS_LO_N  = cas_lo_n_q;
    assign bus.WE_N      = we_n_q;
    assign bus.DTACK_EXP = dtack_q;

endmodule
